// File: rtl/hamming_stream_encoder.sv
// hamming_stream_encoder: systematic Hamming (optionally SECDED) encoder with valid/ready
// flow control; emits each codeword as one parallel word or bit-serially, position 1 first.
module hamming_stream_encoder #(
   parameter int R      = 3,
   parameter int EXT    = 0,
   parameter int SERIAL = 0
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [2**R-R-2:0]                              in_data,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [(SERIAL != 0 ? 1 : 2**R-1+EXT)-1:0]      out_data,
   output logic                                           out_last,
   output logic [15:0]                                    word_count
);
   localparam int N  = 2**R - 1;
   localparam int K  = N - R;
   localparam int W  = N + EXT;
   localparam int CW = $clog2(W);

   typedef enum logic {IDLE, SHIFT} state_t;

   // Data fills the non-power-of-two positions in order; parity positions are folded in after.
   function automatic logic [W-1:0] encode(input logic [K-1:0] u);
      logic [W-1:0] c;
      logic [K-1:0] d;
      c = '0;
      d = u;
      for (int i = 1; i <= N; i++)
         if ((i & (i - 1)) != 0) begin
            c[i-1] = d[0];
            d = d >> 1;
         end
      for (int j = 0; j < R; j++)
         for (int i = 3; i <= N; i++)
            if ((i & (i - 1)) != 0 && i[j])
               c[(1 << j) - 1] ^= c[i-1];
      if (EXT != 0) c[W-1] = ^c[N-1:0];
      return c;
   endfunction

   logic        done;
   logic [15:0] word_count_q, word_count_d;

   always_comb word_count_d = done ? word_count_q + 16'd1 : word_count_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) word_count_q <= '0;
      else word_count_q <= word_count_d;

   assign word_count = word_count_q;

   if (SERIAL == 0) begin : g_par
      logic         valid_q, valid_d, acc;
      logic [W-1:0] data_q, data_d;
      always_comb begin
         acc       = in_valid && (!valid_q || out_ready);
         in_ready  = !valid_q || out_ready;
         valid_d   = acc || (valid_q && !out_ready);
         data_d    = acc ? encode(in_data) : data_q;
         done      = valid_q && out_ready;
         out_valid = valid_q;
         out_last  = valid_q;
         out_data  = data_q;
      end
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
   end else begin : g_ser
      state_t        state_q, state_d;
      logic [W-1:0]  sreg_q, sreg_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          acc;
      always_comb begin
         out_valid = state_q == SHIFT;
         out_last  = out_valid && cnt_q == CW'(W - 1);
         out_data  = out_valid ? sreg_q[cnt_q] : 1'b0;
         in_ready  = state_q == IDLE || (out_ready && out_last);
         acc       = in_valid && in_ready;
         done      = out_valid && out_ready && out_last;
         state_d   = state_q;
         sreg_d    = sreg_q;
         cnt_d     = cnt_q;
         // A reload on the last-bit handshake takes priority over dropping back to IDLE.
         if (acc) begin
            state_d = SHIFT;
            sreg_d  = encode(in_data);
            cnt_d   = '0;
         end else if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (out_valid && out_ready) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
         end
   end
endmodule

// File: tb/tb_hamming_stream_encoder.sv
// tb_hamming_stream_encoder: drives six encoder configurations (R=3/4, EXT=0/1, parallel/serial)
// against a syndrome-based reference model plus hand-computed codewords.
module tb_hamming_stream_encoder;
   localparam int ND = 6;
   localparam int RR [ND] = '{3, 3, 3, 3, 4, 4};
   localparam int EE [ND] = '{0, 1, 0, 1, 0, 1};
   localparam int SS [ND] = '{0, 0, 1, 1, 0, 1};
   localparam logic [3:0] TU  [4] = '{4'hB, 4'h1, 4'h0, 4'hF};
   localparam logic [7:0] TE0 [4] = '{8'h55, 8'h07, 8'h00, 8'h7F};
   localparam logic [7:0] TE1 [4] = '{8'h55, 8'h87, 8'h00, 8'hFF};
   localparam int LIMIT = 60000;

   logic        clk, rst;
   logic        iv [ND], ordy [ND], ir [ND], ov [ND], ol [ND];
   logic [15:0] idat [ND], od [ND], wc [ND];
   int          n_chk, n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int K  = 2**RR[g] - 1 - RR[g];
      localparam int OW = SS[g] != 0 ? 1 : 2**RR[g] - 1 + EE[g];
      logic [OW-1:0] o;
      hamming_stream_encoder #(.R(RR[g]), .EXT(EE[g]), .SERIAL(SS[g])) dut (
         .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(idat[g][K-1:0]),
         .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(o), .out_last(ol[g]),
         .word_count(wc[g]));
      assign od[g] = 16'(o);
   end

   // Parity chosen so the XOR of the indices of all set positions is zero.
   function automatic logic [15:0] ref_enc(input int r, input int ext, input logic [15:0] u);
      logic [15:0] c;
      int k, s;
      c = '0;
      k = 0;
      s = 0;
      for (int i = 1; i < (1 << r); i++)
         if ((i & (i - 1)) != 0) begin
            c[i-1] = u[k];
            if (u[k]) s ^= i;
            k++;
         end
      for (int j = 0; j < r; j++) c[(1 << j) - 1] = s[j];
      if (ext != 0) c[(1 << r) - 1] = ^c;
      return c;
   endfunction

   function automatic int syndrome(input int r, input int ext, input logic [15:0] c);
      int s;
      s = 0;
      for (int i = 1; i < (1 << r); i++) if (c[i-1]) s ^= i;
      if (ext != 0 && ^c) s |= 256;
      return s;
   endfunction

   task automatic chk(input string nm, input int g, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, g, $time, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input int g, input logic act, input logic exp);
      chk(nm, g, 16'(act), 16'(exp));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int g = 0; g < ND; g++) iv[g] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [15:0] q [ND][$];
   int          b [ND];
   logic [15:0] nw [ND], asm_w [ND];

   always @(negedge clk) begin : cmp
      int w;
      logic ev, er, lastb;
      logic [15:0] cw;
      for (int g = 0; g < ND; g++) begin
         w = (1 << RR[g]) - 1 + EE[g];
         if (rst) begin
            q[g].delete();
            b[g] = 0;
            nw[g] = '0;
            asm_w[g] = '0;
            chk1("rst_out_valid", g, ov[g], 1'b0);
            chk1("rst_out_last", g, ol[g], 1'b0);
            chk("rst_out_data", g, od[g], 16'd0);
            chk("rst_word_count", g, wc[g], 16'd0);
         end else begin
            ev = q[g].size() != 0;
            lastb = SS[g] == 0 || b[g] == w - 1;
            er = !ev || (ordy[g] && lastb);
            chk1("out_valid", g, ov[g], ev);
            chk1("in_ready", g, ir[g], er);
            chk("word_count", g, wc[g], nw[g]);
            chk1("out_last", g, ol[g], ev && lastb);
            if (ev) begin
               cw = q[g][0];
               chk("out_data", g, od[g], SS[g] != 0 ? 16'(cw[b[g]]) : cw);
               if (ordy[g]) begin
                  asm_w[g][b[g]] = od[g][0];
                  b[g]++;
                  if (SS[g] == 0 || b[g] == w) begin
                     chk("syndrome", g,
                         16'(syndrome(RR[g], EE[g], SS[g] != 0 ? asm_w[g] : od[g])), 16'd0);
                     void'(q[g].pop_front());
                     b[g] = 0;
                     nw[g]++;
                  end
               end
            end
            if (iv[g] && er) q[g].push_back(ref_enc(RR[g], EE[g], idat[g]));
         end
      end
   end

   initial begin : main
      logic [13:0] sb;
      int nu [ND], tot [ND], cyc;
      logic acc [ND];
      logic all_done;
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      for (int g = 0; g < ND; g++) begin
         iv[g] = 1'b0;
         ordy[g] = 1'b1;
         idat[g] = '0;
      end
      chk("model_enc", -1, ref_enc(3, 0, 16'hB), 16'h55);
      chk("model_enc", -1, ref_enc(3, 0, 16'h1), 16'h07);
      chk("model_enc", -1, ref_enc(3, 1, 16'h1), 16'h87);
      chk("model_enc", -1, ref_enc(3, 1, 16'hF), 16'hFF);
      chk("model_enc", -1, ref_enc(4, 0, 16'h1), 16'h07);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Hand-computed parallel codewords, EXT=0 and EXT=1 side by side.
      for (int t = 0; t < 4; t++) begin
         @(posedge clk);
         #1;
         iv[0] = 1'b1;
         iv[1] = 1'b1;
         idat[0] = 16'(TU[t]);
         idat[1] = 16'(TU[t]);
         @(posedge clk);
         #1;
         iv[0] = 1'b0;
         iv[1] = 1'b0;
         @(negedge clk);
         chk("lit_par_e0", 0, od[0], 16'(TE0[t]));
         chk("lit_par_e1", 1, od[1], 16'(TE1[t]));
      end

      // Parallel back-pressure: held word stays put, in_ready low, next word one cycle after release.
      @(posedge clk);
      #1;
      iv[0] = 1'b1;
      idat[0] = 16'h1;
      ordy[0] = 1'b0;
      @(posedge clk);
      #1;
      idat[0] = 16'hB;
      repeat (5) begin
         @(negedge clk);
         chk("stall_data", 0, od[0], 16'h07);
         chk1("stall_in_ready", 0, ir[0], 1'b0);
         chk1("stall_valid", 0, ov[0], 1'b1);
      end
      @(posedge clk);
      #1;
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      @(negedge clk);
      chk("stall_next", 0, od[0], 16'h55);
      chk1("stall_next_valid", 0, ov[0], 1'b1);

      // Serial: 0001 then queued 1011, back to back.
      do_reset();
      sb = 14'b1010101_0000111;
      @(posedge clk);
      #1;
      iv[2] = 1'b1;
      idat[2] = 16'h1;
      @(posedge clk);
      #1;
      idat[2] = 16'hB;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         chk1("ser_bit", 2, od[2][0], sb[k]);
         chk1("ser_last", 2, ol[2], k == 6 || k == 13);
         chk1("ser_valid", 2, ov[2], 1'b1);
         @(posedge clk);
         #1;
         if (k == 6) iv[2] = 1'b0;
      end
      @(negedge clk);
      chk("ser_count", 2, wc[2], 16'd2);
      chk1("ser_idle", 2, ov[2], 1'b0);

      // Asynchronous reset in the middle of bit 3; next word restarts at bit 0.
      @(posedge clk);
      #1;
      iv[2] = 1'b1;
      idat[2] = 16'hF;
      @(posedge clk);
      #1;
      iv[2] = 1'b0;
      repeat (4) @(negedge clk);
      chk1("pre_rst_valid", 2, ov[2], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("async_rst_valid", 2, ov[2], 1'b0);
      chk("async_rst_count", 2, wc[2], 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      iv[2] = 1'b1;
      idat[2] = 16'h1;
      @(posedge clk);
      #1;
      iv[2] = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk1("post_rst_bit", 2, od[2][0], sb[k]);
         chk1("post_rst_last", 2, ol[2], k == 6);
      end

      // Exhaustive sweep on every configuration with random sink stalls.
      do_reset();
      for (int g = 0; g < ND; g++) begin
         nu[g] = 0;
         tot[g] = 1 << ((1 << RR[g]) - 1 - RR[g]);
         iv[g] = 1'b1;
         idat[g] = '0;
         ordy[g] = $urandom_range(0, 7) != 0;
      end
      cyc = 0;
      all_done = 1'b0;
      while (!all_done && cyc < LIMIT) begin
         @(negedge clk);
         for (int g = 0; g < ND; g++) acc[g] = iv[g] && ir[g];
         @(posedge clk);
         #1;
         all_done = 1'b1;
         for (int g = 0; g < ND; g++) begin
            if (acc[g]) nu[g]++;
            iv[g] = nu[g] < tot[g];
            idat[g] = 16'(nu[g]);
            ordy[g] = $urandom_range(0, 7) != 0;
            if (nu[g] < tot[g] || ov[g]) all_done = 1'b0;
         end
         cyc++;
      end
      chk1("sweep_timeout", -1, cyc < LIMIT, 1'b1);
      @(negedge clk);
      for (int g = 0; g < ND; g++) chk("sweep_count", g, wc[g], 16'(tot[g]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
